// File: rtl/seven_segment_scanner_pkg.sv
// Shared constants and helpers for the seven-segment scanner.
// Segment order is {g,f,e,d,c,b,a}. The cathodes are active-low.
package seven_segment_pkg;

  // Pattern with every cathode off (all segments dark).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low hex glyphs for 0..F. The lower-case glyphs are used for b and d.
  localparam logic [6:0] SEG_DECODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    return SEG_DECODE[nib];
  endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Bundle that carries the scanner's data inputs and its pin-side outputs.
// The master modport drives the digit data. The slave modport (the scanner) drives the pins.
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [6:0]              sevenSegment;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    frame_done;

  modport master (
    output value, dp, digit_en,
    input  sevenSegment, dp_out, anode, frame_done
  );

  modport slave (
    input  value, dp, digit_en,
    output sevenSegment, dp_out, anode, frame_done
  );
endinterface

// File: rtl/seven_segment_scanner_tick_gen.sv
// Clock divider for the scanner. It emits a one-clk tick every CLK_DIV clocks.
// When CLK_DIV is 1, the tick is high on every clock.
module seven_segment_tick_gen #(
  parameter int CLK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] r_div;

  assign o_tick = (r_div == DW'(CLK_DIV - 1));

  // Free-running divider that wraps on the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_div <= '0;
    else if (o_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end
endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode seven-segment scanner.
// Each digit slot has BLANK_TICKS ticks with all anodes off (ghost suppression),
// followed by ON_TICKS ticks with the digit driven.
// Inputs are snapshotted once per frame, so a frame never shows torn data.
// Optional macro SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int CLK_DIV     = 100000,
  parameter int BLANK_TICKS = 1,
  parameter int ON_TICKS    = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seven_segment_scanner_if.slave  bus
);
  localparam int SLOT = BLANK_TICKS + ON_TICKS;
  localparam int PW   = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    w_tick;
  logic [PW-1:0]           r_phase;
  logic [IW-1:0]           r_idx;
  logic                    r_run;       // 0 until the first tick enters digit 0 / phase 0
  logic [4*NUM_DIGITS-1:0] r_snap_val;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic [NUM_DIGITS-1:0]   r_snap_en;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [6:0]              r_seg;
  logic                    r_dp_out;
  logic                    r_frame_done;

  logic                    w_phase_wrap;
  logic                    w_idx_last;
  logic                    w_frame_start;
  logic [PW-1:0]           w_phase_next;
  logic [IW-1:0]           w_idx_next;
  logic [4*NUM_DIGITS-1:0] w_snap_val_next;
  logic [NUM_DIGITS-1:0]   w_snap_dp_next;
  logic [NUM_DIGITS-1:0]   w_snap_en_next;
  logic [NUM_DIGITS-1:0]   w_en_eff;
  logic                    w_drive;
  logic [NUM_DIGITS-1:0]   w_anode_next;
  logic [6:0]              w_seg_next;
  logic                    w_dp_next;

  seven_segment_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  // The position that the next tick moves to. The first tick after reset lands on (0,0).
  assign w_phase_wrap  = (r_phase == PW'(SLOT - 1));
  assign w_idx_last    = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_frame_start = !r_run || (w_phase_wrap && w_idx_last);
  assign w_phase_next  = (!r_run || w_phase_wrap) ? '0 : r_phase + 1'b1;
  assign w_idx_next    = !r_run ? '0 :
                         (w_phase_wrap ? (w_idx_last ? '0 : r_idx + 1'b1) : r_idx);

  // The outputs are computed from the snapshot that is valid once the tick lands.
  // This makes a frame-start drive phase use the new data.
  assign w_snap_val_next = w_frame_start ? bus.value    : r_snap_val;
  assign w_snap_dp_next  = w_frame_start ? bus.dp       : r_snap_dp;
  assign w_snap_en_next  = w_frame_start ? bus.digit_en : r_snap_en;

  generate
    if (BLANK_TICKS == 0) begin : g_no_blank
      assign w_drive = 1'b1;
    end else begin : g_blank
      assign w_drive = (w_phase_next >= PW'(BLANK_TICKS));
    end
  endgenerate

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
  // A digit above 0 is suppressed when it and every higher digit are zero and its dp is off.
  always_comb begin
    logic acc;
    acc      = 1'b1;
    w_en_eff = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc         = acc & (w_snap_val_next[4*k +: 4] == 4'h0);
      w_en_eff[k] = w_snap_en_next[k] & ~((k != 0) && acc && !w_snap_dp_next[k]);
    end
  end
`else
  assign w_en_eff = w_snap_en_next;
`endif

  // Pin pattern for the landing position. Disabled digits look exactly like a blank phase.
  always_comb begin
    w_anode_next = '1;
    w_seg_next   = SEG_OFF;
    w_dp_next    = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_drive && (w_idx_next == IW'(k)) && w_en_eff[k]) begin
        w_anode_next[k] = 1'b0;
        w_seg_next      = seg_decode(w_snap_val_next[4*k +: 4]);
        w_dp_next       = ~w_snap_dp_next[k];
      end
    end
  end

  // Sequencer, snapshot and registered pins. Everything moves only on a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase      <= '0;
      r_idx        <= '0;
      r_run        <= 1'b0;
      r_snap_val   <= '0;
      r_snap_dp    <= '0;
      r_snap_en    <= '0;
      r_anode      <= '1;
      r_seg        <= SEG_OFF;
      r_dp_out     <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_tick) begin
        r_run        <= 1'b1;
        r_phase      <= w_phase_next;
        r_idx        <= w_idx_next;
        r_snap_val   <= w_snap_val_next;
        r_snap_dp    <= w_snap_dp_next;
        r_snap_en    <= w_snap_en_next;
        r_anode      <= w_anode_next;
        r_seg        <= w_seg_next;
        r_dp_out     <= w_dp_next;
        r_frame_done <= w_frame_start;
      end
    end
  end

  assign bus.anode        = r_anode;
  assign bus.sevenSegment = r_seg;
  assign bus.dp_out       = r_dp_out;
  assign bus.frame_done   = r_frame_done;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Scoreboard bench for seven_segment_scanner (4 digits, slot = 8 clk, frame = 32 clk).
// Each driven input set is queued. At every frame start, the latest queued set becomes the expectation for that frame.
module tb_seven_segment_scanner;
  localparam int N     = 4;
  localparam int CD    = 2;
  localparam int BT    = 1;
  localparam int OT    = 3;
  localparam int SLOT  = BT + OT;
  localparam int FRAME = N * SLOT * CD;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  e;
  } stim_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  stim_t sb[$];
  int    checks = 0;
  int    errors = 0;
  logic [6:0] dec_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  always #5 clk = ~clk;

  seven_segment_scanner_if #(.NUM_DIGITS(N)) bus ();

  seven_segment_scanner #(
    .NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_TICKS(BT), .ON_TICKS(OT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic drive(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    bus.value    = v;
    bus.dp       = d;
    bus.digit_en = e;
    sb.push_back({v, d, e});
  endtask

  // Checks one whole frame: 32 samples, taken at negedges starting with the frame_done sample.
  task automatic check_frame(input bit sync, input bit chg, input int chg_at,
                             input stim_t nxt, input string tag);
    stim_t      exp;
    int         waited;
    int         t, dig, ph;
    logic       en, nz;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    @(negedge clk);
    waited = 1;
    if (sync) begin
      while (bus.frame_done !== 1'b1 && waited < 100) begin
        @(negedge clk);
        waited++;
      end
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    while (sb.size() > 1) void'(sb.pop_front());
    exp = sb[0];
    $display("frame %s value=%h dp=%b en=%b", tag, exp.v, exp.d, exp.e);
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      t   = c / CD;
      dig = t / SLOT;
      ph  = t % SLOT;
      en  = exp.e[dig];
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
      nz = 1'b0;
      for (int j = dig; j < N; j++) if (exp.v[4*j +: 4] != 4'h0) nz = 1'b1;
      if (dig > 0 && !nz && !exp.d[dig]) en = 1'b0;
`else
      nz = 1'b1;
`endif
      if (ph >= BT && en) begin
        ea = 4'hF;
        ea[dig] = 1'b0;
        es = dec_tab[exp.v[4*dig +: 4]];
        ed = ~exp.d[dig];
      end else begin
        ea = 4'hF;
        es = 7'h7F;
        ed = 1'b1;
      end
      checks++;
      if (bus.anode !== ea || bus.sevenSegment !== es || bus.dp_out !== ed ||
          bus.frame_done !== (c == 0)) begin
        errors++;
        $display("FAIL %s c=%0d nz=%b anode=%h want %h seg=%h want %h dp_out=%b want %b frame_done=%b want %b",
                 tag, c, nz, bus.anode, ea, bus.sevenSegment, es, bus.dp_out, ed,
                 bus.frame_done, (c == 0));
      end
      if (chg && c == chg_at) drive(nxt.v, nxt.d, nxt.e);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    checks++;
    if (bus.anode !== 4'hF || bus.sevenSegment !== 7'h7F || bus.dp_out !== 1'b1 ||
        bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s anode=%h want f seg=%h want 7f dp_out=%b want 1 frame_done=%b want 0",
               tag, bus.anode, bus.sevenSegment, bus.dp_out, bus.frame_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sb.delete();
    drive(16'h3210, 4'h0, 4'hF);
    repeat (3) @(negedge clk);
    check_reset_pins("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_pins("reset_release");
    check_frame(1'b0, 1'b0, 0, '0, "first_frame");
    check_frame(1'b0, 1'b0, 0, '0, "second_frame");
  endtask

  task automatic test_decode();
    stim_t s;
    drive(16'h0000, 4'h0, 4'hF);
    for (int k = 0; k < 16; k++) begin
      s = {16'(k + 1), 4'h0, 4'hF};
      check_frame(1'b0, (k < 15), 10, s, "decode");
    end
  endtask

  task automatic test_coherence();
    drive(16'h1111, 4'h0, 4'hF);
    check_frame(1'b0, 1'b1, 18, {16'h2222, 4'h0, 4'hF}, "coherent_old");
    check_frame(1'b0, 1'b0, 0, '0, "coherent_new");
  endtask

  task automatic test_enable_dp();
    drive(16'h4321, 4'b0010, 4'b1010);
    check_frame(1'b0, 1'b0, 0, '0, "enable_dp_a");
    check_frame(1'b0, 1'b0, 0, '0, "enable_dp_b");
  endtask

  task automatic test_midframe_reset();
    drive(16'h3210, 4'h0, 4'hF);
    check_frame(1'b0, 1'b0, 0, '0, "pre_reset");
    @(negedge clk);
    repeat (18) @(negedge clk);
    checks++;
    if (bus.anode !== 4'hB || bus.sevenSegment !== 7'h24) begin
      errors++;
      $display("FAIL midframe_position anode=%h want b seg=%h want 24", bus.anode, bus.sevenSegment);
    end
    #1 rst_n = 1'b0;
    #1 check_reset_pins("async_reset");
    repeat (2) @(negedge clk);
    check_reset_pins("midframe_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_pins("midframe_release");
    check_frame(1'b0, 1'b0, 0, '0, "restart_frame");
  endtask

  task automatic test_leading_zero();
    drive(16'h0050, 4'h0, 4'hF);
    check_frame(1'b0, 1'b0, 0, '0, "leading_zero_a");
    check_frame(1'b0, 1'b0, 0, '0, "leading_zero_b");
  endtask

  initial begin
    bus.value    = '0;
    bus.dp       = '0;
    bus.digit_en = '0;
    test_reset();
    test_decode();
    test_coherence();
    test_enable_dp();
    test_midframe_reset();
    test_leading_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
- Parametrised time-multiplexed driver for a bank of common-anode seven-segment digits. Successor to the fixed 5-digit scanner.
- Generalised in digit count, refresh rate and per-digit blanking. Adds full hex decode per digit, decimal points, per-digit enable, frame-coherent input snapshot, inter-digit ghost blanking and a frame-done strobe.
- Sits between the counter/datapath logic and the board's seg/anode pins.

Parameters:
- NUM_DIGITS, 8: number of digits/anodes, 1..16.
- CLK_DIV, 100000: clk cycles per scan tick, >=1.
- BLANK_TICKS, 1: ticks per slot with all anodes off (ghost suppression), >=0.
- ON_TICKS, 7: ticks per slot with the digit driven, >=1.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- value, input, 4*NUM_DIGITS: hex nibble per digit; digit i = value[4i+3:4i].
- dp, input, NUM_DIGITS: decimal point request per digit, 1 = lit.
- digit_en, input, NUM_DIGITS: 1 = digit displayed, 0 = anode held off for its slot.
- sevenSegment, output, 7: cathodes {g,f,e,d,c,b,a}, active-low.
- dp_out, output, 1: decimal-point cathode, active-low.
- anode, output, NUM_DIGITS: anodes, active-low, at most one low.
- frame_done, output, 1: one-clk pulse at start of each new frame.

Behaviour:
- Reset (async, rst_n=0):
  - anode all 1; sevenSegment = 7'h7F; dp_out = 1; frame_done = 0.
  - Divider, phase and index counters = 0.
  - Snapshot registers = 0.
  - Asserting reset mid-frame forces these values immediately. Scanning restarts at digit 0, phase 0.
- Tick generation:
  - div counter runs 0..CLK_DIV-1; tick = (div == CLK_DIV-1).
  - CLK_DIV=1 gives a tick every clk.
- Slot sequencing:
  - slot = BLANK_TICKS+ON_TICKS ticks. Phase counter 0..slot-1 advances on tick.
  - On phase wrap, index advances 0..NUM_DIGITS-1 and wraps to 0. No skipping: disabled digits still consume their slot, so brightness stays constant.
- Output phases:
  - BLANK phase (phase < BLANK_TICKS): anode all 1, sevenSegment 7'h7F, dp_out 1.
  - DRIVE phase (phase >= BLANK_TICKS), if snap_en[idx] = 1: anode[idx] = 0, others 1; sevenSegment = decode(snap_value[idx]); dp_out = ~snap_dp[idx].
  - DRIVE phase, if snap_en[idx] = 0: identical to BLANK.
- Output registration and latency:
  - All outputs are registered and change only on the clk after a tick. Latency tick -> pins is 1 clk.
  - frame period = NUM_DIGITS*slot*CLK_DIV clks.
- Snapshot:
  - value, dp and digit_en are captured into snapshot registers on the tick that enters index 0, phase 0. This includes the first tick after reset release.
  - Inputs changing mid-frame have no effect until the next frame, so no tearing.
- frame_done: 1 for exactly the clk in which the outputs take the index-0, phase-0 state.
- Decode, active-low gfedcba:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Width rules:
  - Counters are sized with $clog2 of their range (min 1 bit).
  - Index compare against NUM_DIGITS-1; never out of range for non-power-of-2 NUM_DIGITS.

Optional Feature:
- Macro: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN.
- Defined: a digit i > 0 is treated as disabled when snap_value[i] and all higher-index snapshot nibbles are 0 and snap_dp[i] = 0. Digit 0 is always shown per snap_en. Evaluation uses snapshot data only.
- Undefined: zeros are displayed normally; there is no extra logic.

Decomposition:
- Package seven_segment_pkg holds:
  - the 16-entry active-low decode constant array;
  - SEG_OFF = 7'h7F;
  - a decode function.
- One natural sub-module: seven_segment_tick_gen (CLK_DIV divider emitting the one-clk tick). Everything else stays in the scanner.

Test Plan:
- Bench parameters: NUM_DIGITS=4, CLK_DIV=2, BLANK_TICKS=1, ON_TICKS=3 (slot = 8 clk, frame = 32 clk).
- Reset/first frame: hold rst_n=0, value=16'h3210 -> anode=4'hF, sevenSegment=7F, dp_out=1. After release: first DRIVE shows anode=4'hE, seg=40. Digits 1..3 then show 79, 24, 30 on anodes D, B, 7; anode is F during each blank tick.
- Full decode: sweep value nibble 0..F on digit 0 across 16 frames -> seg matches the decode list exactly.
- Frame coherence: change value 16'h1111 -> 16'h2222 while digit 2 is driven -> digits 2..3 still show 79 in that frame. Next frame all show 24. frame_done pulses once per 32 clk.
- Enable/dp: digit_en=4'b1010, dp=4'b0010 -> anode low only for digits 1 and 3. dp_out=0 only during digit 1 drive. Slot timing is unchanged.
- Mid-frame reset: rst_n low during digit 2 -> outputs reach reset values asynchronously. After release, scanning restarts at digit 0.
- Macro defined, value=16'h0050, dp=0 -> digits 3 and 2 blank; digit 1 shows 12; digit 0 shows 40.
